pe_dispatch_scheduler: RTL and testbench

- Job-level scheduler in front of an array of NUM_PE identical PE instances.
- Takes a batch of N jobs from the top-level controller and issues job IDs 0..N-1 in order, one per cycle at most, to free PEs (round-robin start point).
- Tracks per-PE busy state from start/finish handshakes and pulses o_done once every issued job has reported finish.

---
 rtl/pe_dispatch_if.sv | 33 +++
 rtl/pe_dispatch_scheduler.sv | 127 ++++++++++++
 tb/tb_pe_dispatch_scheduler.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/pe_dispatch_if.sv
// Handshake bundle between the top-level controller and pe_dispatch_scheduler.
// The controller side (master) drives batch start, batch size, stall and the
// per-PE finish pulses. The scheduler side (slave) returns the per-PE start
// pulses, job IDs and busy mask, plus the batch status and counters.
interface pe_dispatch_if #(
    parameter int NUM_PE   = 4,
    parameter int JOB_ID_W = 8
);
    logic                         i_start;
    logic [JOB_ID_W:0]            i_num_jobs;
    logic                         i_stall;
    logic [NUM_PE-1:0]            i_pe_finish;
    logic [NUM_PE-1:0]            o_pe_start;
    logic [NUM_PE*JOB_ID_W-1:0]   o_pe_job_id;
    logic [NUM_PE-1:0]            o_pe_busy;
    logic                         o_busy;
    logic                         o_done;
    logic [JOB_ID_W:0]            o_issued;
    logic [JOB_ID_W:0]            o_completed;
    logic                         o_err;

    modport master (
        output i_start, i_num_jobs, i_stall, i_pe_finish,
        input  o_pe_start, o_pe_job_id, o_pe_busy, o_busy, o_done,
               o_issued, o_completed, o_err
    );

    modport slave (
        input  i_start, i_num_jobs, i_stall, i_pe_finish,
        output o_pe_start, o_pe_job_id, o_pe_busy, o_busy, o_done,
               o_issued, o_completed, o_err
    );
endinterface

// File: rtl/pe_dispatch_scheduler.sv
// Job-level scheduler for an array of NUM_PE identical PEs.
// A batch of N jobs is issued in ID order 0..N-1, at most one per cycle, to the
// first free PE found scanning round-robin from the PE after the last one used.
// Busy state per PE follows the start/finish handshakes; o_done pulses once
// all issued jobs have reported finish.
// Ports:
//   i_clk  - clock, everything on the rising edge
//   i_rst  - synchronous active-high reset
//   bus    - pe_dispatch_if slave: start/size/stall/finish in; per-PE start,
//            job ID, busy mask, batch busy/done, issued/completed counts,
//            sticky protocol error out
module pe_dispatch_scheduler #(
    parameter int NUM_PE   = 4,
    parameter int JOB_ID_W = 8
) (
    input  logic         i_clk,
    input  logic         i_rst,
    pe_dispatch_if.slave bus
);
    localparam int RR_W  = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;
    localparam int CNT_W = JOB_ID_W + 1;

    typedef enum logic [1:0] {IDLE, DISPATCH, DRAIN, DONE} state_t;

    state_t                           state, state_nxt;
    logic [RR_W-1:0]                  rr, rr_nxt;
    logic [NUM_PE-1:0]                busy, pe_start;
    logic [NUM_PE-1:0][JOB_ID_W-1:0]  job_id;
    logic [CNT_W-1:0]                 num_jobs, issued, completed;
    logic                             err, done;

    logic                             found, issue;
    logic [RR_W-1:0]                  sel_idx;
    logic [NUM_PE-1:0]                sel_oh, valid_fin, bad_fin;
    logic [CNT_W-1:0]                 fin_cnt;

    // Round-robin pick over the registered busy mask. A PE freed on this edge
    // only becomes eligible next cycle, so start and free never share an edge.
    always_comb begin
        int idx;
        idx     = 0;
        found   = 1'b0;
        sel_idx = '0;
        for (int i = 0; i < NUM_PE; i++) begin
            idx = (int'(rr) + i) % NUM_PE;
            if (!found && !busy[idx[RR_W-1:0]]) begin
                found   = 1'b1;
                sel_idx = idx[RR_W-1:0];
            end
        end
        issue  = (state == DISPATCH) && (issued < num_jobs) && !bus.i_stall && found;
        sel_oh = '0;
        if (issue) sel_oh[sel_idx] = 1'b1;
        rr_nxt = (sel_idx == RR_W'(NUM_PE - 1)) ? '0 : sel_idx + 1'b1;
    end

    // Finishes on busy PEs count; finishes on idle PEs are protocol errors.
    always_comb begin
        valid_fin = bus.i_pe_finish & busy;
        bad_fin   = bus.i_pe_finish & ~busy;
        fin_cnt   = '0;
        for (int i = 0; i < NUM_PE; i++) fin_cnt = fin_cnt + CNT_W'(valid_fin[i]);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (bus.i_start)
                          state_nxt = (bus.i_num_jobs == '0) ? DONE : DISPATCH;
            DISPATCH: if (issue && (issued + CNT_W'(1) == num_jobs)) state_nxt = DRAIN;
            DRAIN:    if (completed == num_jobs) state_nxt = DONE;
            DONE:     state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rr        <= '0;
            busy      <= '0;
            pe_start  <= '0;
            job_id    <= '0;
            num_jobs  <= '0;
            issued    <= '0;
            completed <= '0;
            err       <= 1'b0;
            done      <= 1'b0;
        end else begin
            pe_start <= sel_oh;
            // Registered off the DONE state: the pulse lands as the FSM re-enters IDLE.
            done     <= (state == DONE);
            if (state == IDLE) begin
                // Finishes seen in IDLE are ignored entirely.
                if (bus.i_start) begin
                    num_jobs  <= bus.i_num_jobs;
                    issued    <= '0;
                    completed <= '0;
                    busy      <= '0;
                    err       <= 1'b0;
                end
            end else begin
                busy      <= (busy & ~valid_fin) | sel_oh;
                completed <= completed + fin_cnt;
                if (|bad_fin) err <= 1'b1;
                if (issue) begin
                    job_id[sel_idx] <= issued[JOB_ID_W-1:0];
                    issued          <= issued + CNT_W'(1);
                    rr              <= rr_nxt;
                end
            end
        end
    end

    assign bus.o_pe_start  = pe_start;
    assign bus.o_pe_job_id = job_id;
    assign bus.o_pe_busy   = busy;
    assign bus.o_busy      = (state != IDLE);
    assign bus.o_done      = done;
    assign bus.o_issued    = issued;
    assign bus.o_completed = completed;
    assign bus.o_err       = err;
endmodule

// File: tb/tb_pe_dispatch_scheduler.sv
// Directed bench for pe_dispatch_scheduler (NUM_PE=4, JOB_ID_W=8).
// Inputs are driven 1ns after a rising edge and so are sampled at the next
// edge; outputs are checked at the same point. In each scenario table, row e
// holds the finish mask sampled at edge e and the expected outputs right
// after edge e, where edge 0 is the edge that samples i_start.
// Row vector order: {pe_start, pe_busy, busy, done, err, issued, completed}.
module tb_pe_dispatch_scheduler;
    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;

    pe_dispatch_if #(.NUM_PE(4), .JOB_ID_W(8)) bus ();

    pe_dispatch_scheduler #(.NUM_PE(4), .JOB_ID_W(8)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        logic [28:0] obs;
        rst = 1'b1;
        bus.i_start = 1'b0; bus.i_num_jobs = '0; bus.i_stall = 1'b0; bus.i_pe_finish = '0;
        tick; tick;
        obs = {bus.o_pe_start, bus.o_pe_busy, bus.o_busy, bus.o_done, bus.o_err,
               bus.o_issued, bus.o_completed};
        n_checks++;
        if (obs !== 29'd0) begin
            n_fail++; $display("FAIL reset outputs got %b want 0", obs);
        end
        n_checks++;
        if (bus.o_pe_job_id !== 32'h0) begin
            n_fail++; $display("FAIL reset job_ids got %h want 0", bus.o_pe_job_id);
        end
        rst = 1'b0;
    endtask

    // N=6, each PE finishes 3 edges after its start; a stray i_start mid-batch.
    task automatic test_basic;
        int fin [13], xst [13], xbz [13], xob [13], xdn [13], xis [13], xcp [13];
        logic [28:0] obs, exp;
        fin = '{0,0,0,0,1,2,4,8,1,2,0,0,0};
        xst = '{0,1,2,4,8,1,2,0,0,0,0,0,0};
        xbz = '{0,1,3,7,14,13,11,3,2,0,0,0,0};
        xob = '{1,1,1,1,1,1,1,1,1,1,1,0,0};
        xdn = '{0,0,0,0,0,0,0,0,0,0,0,1,0};
        xis = '{0,1,2,3,4,5,6,6,6,6,6,6,6};
        xcp = '{0,0,0,0,1,2,3,4,5,6,6,6,6};
        bus.i_start = 1'b1; bus.i_num_jobs = 9'd6;
        for (int e = 0; e < 13; e++) begin
            bus.i_pe_finish = 4'(fin[e]);
            if (e == 3) begin bus.i_start = 1'b1; bus.i_num_jobs = 9'd1; end
            tick;
            bus.i_start = 1'b0;
            obs = {bus.o_pe_start, bus.o_pe_busy, bus.o_busy, bus.o_done, bus.o_err,
                   bus.o_issued, bus.o_completed};
            exp = {4'(xst[e]), 4'(xbz[e]), 1'(xob[e]), 1'(xdn[e]), 1'b0,
                   9'(xis[e]), 9'(xcp[e])};
            n_checks++;
            if (obs !== exp) begin
                n_fail++; $display("FAIL basic edge %0d got %b want %b", e, obs, exp);
            end
        end
        bus.i_pe_finish = '0;
        n_checks++;
        if (bus.o_pe_job_id !== 32'h03020504) begin
            n_fail++; $display("FAIL basic job_ids got %h want 03020504", bus.o_pe_job_id);
        end
    endtask

    // N=0 goes straight to DONE: one busy cycle, then the done pulse, no starts.
    task automatic test_zero_jobs;
        int xob [3], xdn [3];
        logic [28:0] obs, exp;
        xob = '{1,0,0};
        xdn = '{0,1,0};
        bus.i_start = 1'b1; bus.i_num_jobs = 9'd0;
        for (int e = 0; e < 3; e++) begin
            tick;
            bus.i_start = 1'b0;
            obs = {bus.o_pe_start, bus.o_pe_busy, bus.o_busy, bus.o_done, bus.o_err,
                   bus.o_issued, bus.o_completed};
            exp = {4'd0, 4'd0, 1'(xob[e]), 1'(xdn[e]), 1'b0, 9'd0, 9'd0};
            n_checks++;
            if (obs !== exp) begin
                n_fail++; $display("FAIL zero_jobs edge %0d got %b want %b", e, obs, exp);
            end
        end
    endtask

    // N=4 with stall high for the first 5 DISPATCH cycles, then stall again
    // through the drain: finishes still count and the batch completes.
    // Round-robin resumes at PE2 (left there by the basic batch).
    task automatic test_stall;
        int st [15], fin [15], xst [15], xbz [15], xob [15], xdn [15], xis [15], xcp [15];
        logic [28:0] obs, exp;
        st  = '{1,1,1,1,1,1,0,0,0,0,1,1,1,1,1};
        fin = '{0,0,0,0,0,0,0,0,0,0,4,11,0,0,0};
        xst = '{0,0,0,0,0,0,4,8,1,2,0,0,0,0,0};
        xbz = '{0,0,0,0,0,0,4,12,13,15,11,0,0,0,0};
        xob = '{1,1,1,1,1,1,1,1,1,1,1,1,1,0,0};
        xdn = '{0,0,0,0,0,0,0,0,0,0,0,0,0,1,0};
        xis = '{0,0,0,0,0,0,1,2,3,4,4,4,4,4,4};
        xcp = '{0,0,0,0,0,0,0,0,0,0,1,4,4,4,4};
        bus.i_start = 1'b1; bus.i_num_jobs = 9'd4;
        for (int e = 0; e < 15; e++) begin
            bus.i_stall     = st[e][0];
            bus.i_pe_finish = 4'(fin[e]);
            tick;
            bus.i_start = 1'b0;
            obs = {bus.o_pe_start, bus.o_pe_busy, bus.o_busy, bus.o_done, bus.o_err,
                   bus.o_issued, bus.o_completed};
            exp = {4'(xst[e]), 4'(xbz[e]), 1'(xob[e]), 1'(xdn[e]), 1'b0,
                   9'(xis[e]), 9'(xcp[e])};
            n_checks++;
            if (obs !== exp) begin
                n_fail++; $display("FAIL stall edge %0d got %b want %b", e, obs, exp);
            end
        end
        bus.i_stall = 1'b0; bus.i_pe_finish = '0;
        n_checks++;
        if (bus.o_pe_job_id !== 32'h01000302) begin
            n_fail++; $display("FAIL stall job_ids got %h want 01000302", bus.o_pe_job_id);
        end
    endtask

    // N=2 on PE2/PE3; a finish from idle PE1 during drain sets the sticky error
    // without being counted, and the batch still completes.
    task automatic test_err;
        int fin [8], xst [8], xbz [8], xob [8], xdn [8], xer [8], xis [8], xcp [8];
        logic [28:0] obs, exp;
        fin = '{0,0,0,2,12,0,0,0};
        xst = '{0,4,8,0,0,0,0,0};
        xbz = '{0,4,12,12,0,0,0,0};
        xob = '{1,1,1,1,1,1,0,0};
        xdn = '{0,0,0,0,0,0,1,0};
        xer = '{0,0,0,1,1,1,1,1};
        xis = '{0,1,2,2,2,2,2,2};
        xcp = '{0,0,0,0,2,2,2,2};
        bus.i_start = 1'b1; bus.i_num_jobs = 9'd2;
        for (int e = 0; e < 8; e++) begin
            bus.i_pe_finish = 4'(fin[e]);
            tick;
            bus.i_start = 1'b0;
            obs = {bus.o_pe_start, bus.o_pe_busy, bus.o_busy, bus.o_done, bus.o_err,
                   bus.o_issued, bus.o_completed};
            exp = {4'(xst[e]), 4'(xbz[e]), 1'(xob[e]), 1'(xdn[e]), 1'(xer[e]),
                   9'(xis[e]), 9'(xcp[e])};
            n_checks++;
            if (obs !== exp) begin
                n_fail++; $display("FAIL err edge %0d got %b want %b", e, obs, exp);
            end
        end
        bus.i_pe_finish = '0;
    endtask

    // N=4, all four PEs finish on one edge; err from the previous batch clears
    // on this start.
    task automatic test_all_finish;
        int fin [9], xst [9], xbz [9], xob [9], xdn [9], xis [9], xcp [9];
        logic [28:0] obs, exp;
        fin = '{0,0,0,0,0,15,0,0,0};
        xst = '{0,1,2,4,8,0,0,0,0};
        xbz = '{0,1,3,7,15,0,0,0,0};
        xob = '{1,1,1,1,1,1,1,0,0};
        xdn = '{0,0,0,0,0,0,0,1,0};
        xis = '{0,1,2,3,4,4,4,4,4};
        xcp = '{0,0,0,0,0,4,4,4,4};
        bus.i_start = 1'b1; bus.i_num_jobs = 9'd4;
        for (int e = 0; e < 9; e++) begin
            bus.i_pe_finish = 4'(fin[e]);
            tick;
            bus.i_start = 1'b0;
            obs = {bus.o_pe_start, bus.o_pe_busy, bus.o_busy, bus.o_done, bus.o_err,
                   bus.o_issued, bus.o_completed};
            exp = {4'(xst[e]), 4'(xbz[e]), 1'(xob[e]), 1'(xdn[e]), 1'b0,
                   9'(xis[e]), 9'(xcp[e])};
            n_checks++;
            if (obs !== exp) begin
                n_fail++; $display("FAIL all_finish edge %0d got %b want %b", e, obs, exp);
            end
        end
        bus.i_pe_finish = '0;
    endtask

    // N=3 on PE0..2, PE0 finishes, reset lands in DRAIN with PE1/PE2 busy.
    // Late finishes are ignored; a following N=1 batch issues to PE0.
    task automatic test_reset_mid_batch;
        int fin [14], xst [14], xbz [14], xob [14], xdn [14], xis [14], xcp [14];
        logic [28:0] obs, exp;
        fin = '{0,0,0,0,1,0,6,6,0,0,1,0,0,0};
        xst = '{0,1,2,4,0,0,0,0,0,1,0,0,0,0};
        xbz = '{0,1,3,7,6,0,0,0,0,1,0,0,0,0};
        xob = '{1,1,1,1,1,0,0,0,1,1,1,1,0,0};
        xdn = '{0,0,0,0,0,0,0,0,0,0,0,0,1,0};
        xis = '{0,1,2,3,3,0,0,0,0,1,1,1,1,1};
        xcp = '{0,0,0,0,1,0,0,0,0,0,1,1,1,1};
        bus.i_start = 1'b1; bus.i_num_jobs = 9'd3;
        for (int e = 0; e < 14; e++) begin
            bus.i_pe_finish = 4'(fin[e]);
            if (e == 5) rst = 1'b1;
            if (e == 8) begin bus.i_start = 1'b1; bus.i_num_jobs = 9'd1; end
            tick;
            bus.i_start = 1'b0;
            rst = 1'b0;
            obs = {bus.o_pe_start, bus.o_pe_busy, bus.o_busy, bus.o_done, bus.o_err,
                   bus.o_issued, bus.o_completed};
            exp = {4'(xst[e]), 4'(xbz[e]), 1'(xob[e]), 1'(xdn[e]), 1'b0,
                   9'(xis[e]), 9'(xcp[e])};
            n_checks++;
            if (obs !== exp) begin
                n_fail++; $display("FAIL rst_mid edge %0d got %b want %b", e, obs, exp);
            end
            if (e == 5) begin
                n_checks++;
                if (bus.o_pe_job_id !== 32'h0) begin
                    n_fail++; $display("FAIL rst_mid job_ids got %h want 0", bus.o_pe_job_id);
                end
            end
        end
        bus.i_pe_finish = '0;
    endtask

    initial begin
        test_reset;
        test_basic;
        test_zero_jobs;
        test_stall;
        test_err;
        test_all_finish;
        test_reset_mid_batch;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
